// File: rtl/bus_source_arbiter.sv
// Bus source arbiter: registered one-cycle grant, hold lock, and a saturating conflict counter.
// Define BUS_ARB_RR_EN for round-robin arbitration; the default build is fixed lowest-index priority.
module bus_source_arbiter #(
  parameter int N_SRC = 24,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_SRC-1:0] req,
  input  logic             hold,
  output logic [SEL_W-1:0] sel_out,
  output logic             sel_valid,
  output logic             conflict,
  output logic [7:0]       conflict_cnt
);

  logic             frozen;
  logic             any_req;
  logic             multi_req;
  logic [SEL_W-1:0] grant_idx;

  // hold only locks a live grant; with no grant it is ignored
  assign frozen    = hold & sel_valid;
  assign any_req   = |req;
  assign multi_req = $countones(req) > 1;

`ifdef BUS_ARB_RR_EN
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cand;
  logic             found;

  // Search starts one past the last grant and wraps at N_SRC-1
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = SEL_W'((int'(ptr) + k) % N_SRC);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr <= SEL_W'(N_SRC - 1);
    end else if (!frozen && any_req) begin
      ptr <= grant_idx;
    end
  end
`else
  // Descending scan so the lowest set index is the last assignment
  always_comb begin
    grant_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = SEL_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      sel_out      <= '0;
      sel_valid    <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (frozen) begin
      conflict <= 1'b0;
    end else begin
      conflict <= multi_req;
      if (multi_req && conflict_cnt != 8'hFF) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end
      // sel_out keeps its last code when nobody requests
      if (any_req) begin
        sel_out   <= grant_idx;
        sel_valid <= 1'b1;
      end else begin
        sel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Scoreboard bench for bus_source_arbiter: a behavioural model queues expected outputs per step.
// Round-robin expectations are used when BUS_ARB_RR_EN is defined.
module tb_bus_source_arbiter;

  localparam int N = 24;
  localparam int W = 5;

  typedef struct {
    logic [W-1:0] sel;
    logic         valid;
    logic         conf;
    logic [7:0]   cnt;
  } exp_t;

  logic          clk;
  logic          clr;
  logic [N-1:0]  req;
  logic          hold;
  logic [W-1:0]  sel_out;
  logic          sel_valid;
  logic          conflict;
  logic [7:0]    conflict_cnt;

  exp_t exp_q[$];

  int tests_run;
  int tests_failed;

  logic [W-1:0] m_sel;
  logic         m_valid;
  logic         m_conf;
  logic [7:0]   m_cnt;
  int           m_ptr;

  bus_source_arbiter #(.N_SRC(N), .SEL_W(W)) dut (
    .clk(clk),
    .clr(clr),
    .req(req),
    .hold(hold),
    .sel_out(sel_out),
    .sel_valid(sel_valid),
    .conflict(conflict),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the outputs must be after the next edge
  task automatic applyStimulus(input logic [N-1:0] r, input logic h, input logic c);
    exp_t e;
    int   win;
    int   idx;
    @(negedge clk);
    req  = r;
    hold = h;
    clr  = c;
    if (c) begin
      m_sel = '0; m_valid = 1'b0; m_conf = 1'b0; m_cnt = '0; m_ptr = N - 1;
    end else if (h && m_valid) begin
      m_conf = 1'b0;
    end else begin
      m_conf = ($countones(r) >= 2);
      if (m_conf && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      if (r != '0) begin
        win = -1;
`ifdef BUS_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
          idx = (m_ptr + k) % N;
          if (win < 0 && r[idx]) win = idx;
        end
`else
        for (int i = 0; i < N; i++) begin
          idx = i;
          if (win < 0 && r[idx]) win = idx;
        end
`endif
        m_sel   = W'(win);
        m_valid = 1'b1;
        m_ptr   = win;
      end else begin
        m_valid = 1'b0;
      end
    end
    e.sel = m_sel; e.valid = m_valid; e.conf = m_conf; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    tests_run++;
    assert (exp_q.size() != 0) else begin
      tests_failed++;
      $error("[TB] FAIL %s.queue: observed empty expected entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests_run++;
      assert (sel_out === e.sel) else begin
        tests_failed++;
        $error("[TB] FAIL %s.sel_out: observed %0d expected %0d", tag, sel_out, e.sel);
      end
      tests_run++;
      assert (sel_valid === e.valid) else begin
        tests_failed++;
        $error("[TB] FAIL %s.sel_valid: observed %0b expected %0b", tag, sel_valid, e.valid);
      end
      tests_run++;
      assert (conflict === e.conf) else begin
        tests_failed++;
        $error("[TB] FAIL %s.conflict: observed %0b expected %0b", tag, conflict, e.conf);
      end
      tests_run++;
      assert (conflict_cnt === e.cnt) else begin
        tests_failed++;
        $error("[TB] FAIL %s.conflict_cnt: observed %0d expected %0d", tag, conflict_cnt, e.cnt);
      end
    end
  endtask

  // Hard time limit so a stuck run still reports
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clr  = 1'b1;
    req  = '0;
    hold = 1'b0;
    m_sel = '0; m_valid = 1'b0; m_conf = 1'b0; m_cnt = '0; m_ptr = N - 1;

    applyStimulus('0, 1'b0, 1'b1);            checkOutput("reset0");
    applyStimulus(24'hFFFFFF, 1'b1, 1'b1);    checkOutput("reset1");

    applyStimulus(24'h000004, 1'b0, 1'b0);    checkOutput("single2");
    applyStimulus(24'h000000, 1'b0, 1'b0);    checkOutput("idle_keep");

    applyStimulus(24'h110000, 1'b0, 1'b0);    checkOutput("pair16_20");

    for (int i = 0; i < 4; i++) begin
      applyStimulus(24'h000009, 1'b0, 1'b0);  checkOutput("pair0_3");
    end

    applyStimulus(24'h000020, 1'b0, 1'b0);    checkOutput("grant5");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(24'h000001, 1'b1, 1'b0);  checkOutput("hold5");
    end
    applyStimulus(24'h000001, 1'b0, 1'b0);    checkOutput("release0");

    applyStimulus(24'h000000, 1'b0, 1'b0);    checkOutput("idle");
    applyStimulus(24'h000008, 1'b1, 1'b0);    checkOutput("hold_ignored");

    applyStimulus(24'h800000, 1'b0, 1'b0);    checkOutput("top23");

    applyStimulus(24'h000080, 1'b0, 1'b0);    checkOutput("grant7");
    applyStimulus(24'h000080, 1'b1, 1'b0);    checkOutput("hold7");
    applyStimulus(24'h000001, 1'b1, 1'b1);    checkOutput("clr_in_hold");
    applyStimulus(24'hFFFFFF, 1'b0, 1'b0);    checkOutput("all_after_clr");

    for (int i = 0; i < 300; i++) begin
      applyStimulus(24'h000003, 1'b0, 1'b0);  checkOutput("saturate");
    end
    applyStimulus(24'h000003, 1'b0, 1'b0);    checkOutput("sat_hold");
    applyStimulus(24'h000000, 1'b0, 1'b0);    checkOutput("sat_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
